// File: rtl/sketch_frame_builder.sv
// -----------------------------------------------------------------------------
// sketch_frame_builder
//
// Turns debounced keypad presses into a 4x4 pixel drawing. When the drawing is
// submitted, it is offered to the O/X classifier over a valid/ready handshake.
// The drawing is cleared once the classifier accepts it.
//
// Parameters
//   DEBOUNCE_CYC : number of cycles a key code must stay stable before it is
//                  accepted (at least 2)
//   SUB_DEB_CYC  : number of stable cycles required on btn_submit / btn_clear
//
// Ports
//   clk          : system clock
//   rst          : asynchronous reset, active low
//   key_flags    : one-hot key bus (bit0=A, 1=1, 2=2, 3=3, 4=B ... 13=*, 14=0, 15=#)
//   key_valid    : qualifier for key_flags; when low the bus reads as all zero
//   btn_submit   : raw submit button, active high
//   btn_clear    : raw clear button, active high
//   frame_ready  : the classifier accepts the frame this cycle
//   frame        : frame offered to the classifier; stable while frame_valid=1
//   frame_valid  : frame offer; held high until frame_ready=1
//   live_frame   : frame currently being drawn
//   pixel_count  : number of set bits in live_frame
//   busy         : high while a frame is being offered
//
// Build option
//   SKETCH_TOGGLE_EN : when defined, a key press toggles its pixel instead of
//                      only setting it. A drawing toggled back to empty
//                      returns to idle.
// -----------------------------------------------------------------------------
module sketch_frame_builder #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int SUB_DEB_CYC  = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] key_flags,
    input  logic        key_valid,
    input  logic        btn_submit,
    input  logic        btn_clear,
    input  logic        frame_ready,
    output logic [15:0] frame,
    output logic        frame_valid,
    output logic [15:0] live_frame,
    output logic [4:0]  pixel_count,
    output logic        busy
);

    // Counter widths are sized with +1 so that a cycle count of 1 still
    // produces a counter of non-zero width.
    localparam int KCW = $clog2(DEBOUNCE_CYC + 1);
    localparam int BCW = $clog2(SUB_DEB_CYC + 1);
    localparam logic [KCW-1:0] KEY_LAST = KCW'(DEBOUNCE_CYC - 1);
    localparam logic [BCW-1:0] BTN_LAST = BCW'(SUB_DEB_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_OFFER
    } state_t;

    // -------------------------------------------------------------------------
    // Key sampling and debounce
    // -------------------------------------------------------------------------
    logic [15:0]    raw_code;
    logic [15:0]    low_code;
    logic [15:0]    code_s_reg;
    logic [15:0]    code_d_reg;
    logic [15:0]    key_stable_reg;
    logic [KCW-1:0] key_cnt_reg;
    logic           key_settle;
    logic           key_accept;

    assign raw_code = key_valid ? key_flags : 16'h0000;
    // If several keys are pressed together, keep only the lowest-index bit.
    // x & -x isolates that bit.
    assign low_code = raw_code & (~raw_code + 16'd1);

    // code_d_reg lags code_s_reg by one cycle. A mismatch between the two
    // means that code_s changed on the previous edge, so the stability counter
    // restarts. This extra stage gives the press-to-pixel latency of
    // DEBOUNCE_CYC+1 edges after the first sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code_s_reg     <= '0;
            code_d_reg     <= '0;
            key_stable_reg <= '0;
            key_cnt_reg    <= '0;
        end else begin
            code_s_reg <= low_code;
            code_d_reg <= code_s_reg;
            if (code_s_reg != code_d_reg) begin
                key_cnt_reg <= '0;
            end else if (key_cnt_reg != KEY_LAST) begin
                key_cnt_reg <= key_cnt_reg + 1'b1;
            end
            if (key_settle) begin
                key_stable_reg <= code_s_reg;
            end
        end
    end

    assign key_settle = (code_s_reg == code_d_reg) && (key_cnt_reg == KEY_LAST);
    // Only a change of the stable code to a non-zero value counts as a press.
    // A release produces no event, and a held key matches the stable code, so
    // it fires only once.
    assign key_accept = key_settle && (code_s_reg != key_stable_reg) &&
                        (code_s_reg != 16'h0000);

    // -------------------------------------------------------------------------
    // Button debouncers: index 0 = submit, index 1 = clear
    // -------------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] btn_rise;
    logic       submit_rise;
    logic       clear_rise;

    assign btn_raw = {btn_clear, btn_submit};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic           s_reg;
        logic           d_reg;
        logic           stable_reg;
        logic [BCW-1:0] cnt_reg;
        logic           settle;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s_reg      <= 1'b0;
                d_reg      <= 1'b0;
                stable_reg <= 1'b0;
                cnt_reg    <= '0;
            end else begin
                s_reg <= btn_raw[gi];
                d_reg <= s_reg;
                if (s_reg != d_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg != BTN_LAST) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
                if (settle) begin
                    stable_reg <= s_reg;
                end
            end
        end

        assign settle       = (s_reg == d_reg) && (cnt_reg == BTN_LAST);
        assign btn_rise[gi] = settle && s_reg && !stable_reg;
    end

    assign submit_rise = btn_rise[0];
    assign clear_rise  = btn_rise[1];

    // -------------------------------------------------------------------------
    // Frame FSM
    // -------------------------------------------------------------------------
    state_t      state_reg;
    state_t      state_next;
    logic [15:0] live_reg;
    logic [15:0] live_next;
    logic [15:0] frame_reg;
    logic [15:0] frame_next;
    logic [4:0]  count_reg;
    logic [4:0]  count_next;
    logic [15:0] key_code;
    logic [15:0] upd_frame;

    assign key_code = key_accept ? code_s_reg : 16'h0000;

`ifdef SKETCH_TOGGLE_EN
    assign upd_frame = live_reg ^ key_code;
`else
    assign upd_frame = live_reg | key_code;
`endif

    always_comb begin
        state_next = state_reg;
        live_next  = live_reg;
        frame_next = frame_reg;
        count_next = 5'd0;

        case (state_reg)
            ST_IDLE: begin
                // The drawing is empty here. Submit and clear have no effect.
                if (key_accept) begin
                    live_next = upd_frame;
                    if (upd_frame != 16'h0000) begin
                        state_next = ST_COLLECT;
                    end
                end
            end

            ST_COLLECT: begin
                if (clear_rise) begin
                    // Clear takes priority over a simultaneous submit.
                    live_next  = 16'h0000;
                    state_next = ST_IDLE;
                end else if (submit_rise) begin
                    // The offered frame includes a key accepted on this edge.
                    live_next = upd_frame;
                    if (upd_frame != 16'h0000) begin
                        frame_next = upd_frame;
                        state_next = ST_OFFER;
                    end else begin
                        // Toggle mode can empty the drawing on this edge.
                        // An empty frame is never offered.
                        state_next = ST_IDLE;
                    end
                end else begin
                    live_next = upd_frame;
                    // Only reachable in toggle mode. In set mode the drawing
                    // never becomes empty here.
                    if (upd_frame == 16'h0000) begin
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_OFFER: begin
                // Keys and buttons are ignored here. Presses made while the
                // frame is offered are dropped, not saved for later.
                if (frame_ready) begin
                    live_next  = 16'h0000;
                    state_next = ST_IDLE;
                end
            end

            default: begin
                live_next  = 16'h0000;
                state_next = ST_IDLE;
            end
        endcase

        // Popcount of the next drawing. pixel_count is updated on the same
        // edge as live_frame, so the two always agree.
        for (int i = 0; i < 16; i++) begin
            count_next = count_next + {4'd0, live_next[i]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            live_reg  <= '0;
            frame_reg <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            live_reg  <= live_next;
            frame_reg <= frame_next;
            count_reg <= count_next;
        end
    end

    // The offer handshake is driven directly from the state register. Reset
    // moves the state to IDLE, so any pending offer is dropped at once.
    assign frame       = frame_reg;
    assign frame_valid = (state_reg == ST_OFFER);
    assign busy        = (state_reg == ST_OFFER);
    assign live_frame  = live_reg;
    assign pixel_count = count_reg;

endmodule

// File: tb/tb_sketch_frame_builder.sv
module tb_sketch_frame_builder;

    logic        clk;
    logic        rst;
    logic [15:0] key_flags;
    logic        key_valid;
    logic        btn_submit;
    logic        btn_clear;
    logic        frame_ready;
    logic [15:0] frame;
    logic        frame_valid;
    logic [15:0] live_frame;
    logic [4:0]  pixel_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    sketch_frame_builder #(
        .DEBOUNCE_CYC(4),
        .SUB_DEB_CYC (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_flags  (key_flags),
        .key_valid  (key_valid),
        .btn_submit (btn_submit),
        .btn_clear  (btn_clear),
        .frame_ready(frame_ready),
        .frame      (frame),
        .frame_valid(frame_valid),
        .live_frame (live_frame),
        .pixel_count(pixel_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] code;
        logic        valid;
        logic [15:0] exp_live;
        logic [4:0]  exp_cnt;
    } vec_t;

    vec_t vecs [9];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Holds a key long enough for it to be accepted, then releases it long
    // enough for the stable code to return to zero.
    task automatic press(input logic [15:0] code);
        key_flags = code;
        key_valid = 1'b1;
        tick(10);
        key_flags = 16'h0000;
        key_valid = 1'b0;
        tick(6);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_frame_valid"}, {31'd0, frame_valid}, 32'd0);
        chk({tag, "_busy"},        {31'd0, busy},        32'd0);
        chk({tag, "_live"},        {16'd0, live_frame},  32'd0);
        chk({tag, "_count"},       {27'd0, pixel_count}, 32'd0);
    endtask

    initial begin
        // Ring 0x6996, mixed with multi-bit codes and a code with key_valid low.
        vecs[0] = '{16'h0006, 1'b1, 16'h0002, 5'd1};  // bits 1,2 -> lowest bit 1
        vecs[1] = '{16'h0004, 1'b1, 16'h0006, 5'd2};
        vecs[2] = '{16'h0001, 1'b0, 16'h0006, 5'd2};  // key_valid low -> ignored
        vecs[3] = '{16'h0010, 1'b1, 16'h0016, 5'd3};
        vecs[4] = '{16'h0080, 1'b1, 16'h0096, 5'd4};
        vecs[5] = '{16'h0100, 1'b1, 16'h0196, 5'd5};
        vecs[6] = '{16'h0800, 1'b1, 16'h0996, 5'd6};
        vecs[7] = '{16'hA000, 1'b1, 16'h2996, 5'd7};  // bits 13,15 -> bit 13
        vecs[8] = '{16'h4000, 1'b1, 16'h6996, 5'd8};

        rst         = 1'b0;
        key_flags   = 16'h0000;
        key_valid   = 1'b0;
        btn_submit  = 1'b0;
        btn_clear   = 1'b0;
        frame_ready = 1'b0;
        #2;
        check_idle_zero("reset_state");
        chk("reset_frame", {16'd0, frame}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        tick(2);

        // ---- 1: reset in the middle of an offer ----
        press(16'h0001);
        chk("t1_pre_live", {16'd0, live_frame}, 32'h0001);
        btn_submit = 1'b1;
        tick(6);
        chk("t1_offer_valid", {31'd0, frame_valid}, 32'd1);
        chk("t1_offer_frame", {16'd0, frame}, 32'h0001);
        btn_submit = 1'b0;
        key_flags  = 16'h0002;
        key_valid  = 1'b1;
        tick(3);
        #3;
        rst = 1'b0;
        #1;
        check_idle_zero("t1_async_rst");
        chk("t1_async_frame", {16'd0, frame}, 32'd0);
        $display("t1 reset asserted mid-offer: frame_valid=%0d live=%h", frame_valid, live_frame);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick(5);
        chk("t1_latency_early", {16'd0, live_frame}, 32'h0000);
        tick(1);
        chk("t1_latency_live", {16'd0, live_frame}, 32'h0002);
        chk("t1_latency_count", {27'd0, pixel_count}, 32'd1);
        chk("t1_no_offer", {31'd0, frame_valid}, 32'd0);
        $display("t1 key 0002 after reset release: live=%h count=%0d", live_frame, pixel_count);
        key_flags = 16'h0000;
        key_valid = 1'b0;
        tick(6);
        btn_clear = 1'b1;
        tick(6);
        check_idle_zero("t1_clear");
        btn_clear = 1'b0;
        tick(6);

        // ---- 2: bounce rejection ----
        key_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            key_flags = (i % 2 == 0) ? 16'h0010 : 16'h0000;
            tick(2);
        end
        key_flags = 16'h0000;
        key_valid = 1'b0;
        tick(10);
        chk("t2_bounce_live", {16'd0, live_frame}, 32'h0000);
        chk("t2_bounce_count", {27'd0, pixel_count}, 32'd0);
        $display("t2 bouncing key 0010: live=%h", live_frame);

        // ---- 3: draw the O ring with the vector table, then offer it ----
        for (int v = 0; v < 9; v++) begin
            key_flags = vecs[v].code;
            key_valid = vecs[v].valid;
            tick(10);
            chk($sformatf("t3_vec%0d_live", v), {16'd0, live_frame}, {16'd0, vecs[v].exp_live});
            chk($sformatf("t3_vec%0d_count", v), {27'd0, pixel_count}, {27'd0, vecs[v].exp_cnt});
            $display("t3 vec %0d code=%h valid=%0d live=%h count=%0d",
                     v, vecs[v].code, vecs[v].valid, live_frame, pixel_count);
            key_flags = 16'h0000;
            key_valid = 1'b0;
            tick(6);
        end
        btn_submit = 1'b1;
        tick(6);
        btn_submit = 1'b0;
        chk("t3_offer_valid", {31'd0, frame_valid}, 32'd1);
        chk("t3_offer_busy", {31'd0, busy}, 32'd1);
        chk("t3_offer_frame", {16'd0, frame}, 32'h6996);
        for (int c = 0; c < 7; c++) begin
            tick(1);
            chk($sformatf("t3_hold%0d_valid", c), {31'd0, frame_valid}, 32'd1);
            chk($sformatf("t3_hold%0d_frame", c), {16'd0, frame}, 32'h6996);
        end
        frame_ready = 1'b1;
        tick(1);
        frame_ready = 1'b0;
        check_idle_zero("t3_handshake");
        chk("t3_frame_kept", {16'd0, frame}, 32'h6996);
        $display("t3 handshake: frame=%h frame_valid=%0d live=%h", frame, frame_valid, live_frame);

        // ---- 4: submit from idle, repeated press ----
        btn_submit = 1'b1;
        tick(6);
        chk("t4_idle_submit_valid", {31'd0, frame_valid}, 32'd0);
        chk("t4_idle_submit_busy", {31'd0, busy}, 32'd0);
        btn_submit = 1'b0;
        tick(6);
        press(16'h0001);
        chk("t4_first_live", {16'd0, live_frame}, 32'h0001);
        press(16'h0001);
`ifdef SKETCH_TOGGLE_EN
        chk("t4_repress_live", {16'd0, live_frame}, 32'h0000);
        chk("t4_repress_count", {27'd0, pixel_count}, 32'd0);
`else
        chk("t4_repress_live", {16'd0, live_frame}, 32'h0001);
        chk("t4_repress_count", {27'd0, pixel_count}, 32'd1);
`endif
        $display("t4 repeated press 0001: live=%h count=%0d", live_frame, pixel_count);

        // ---- 5: clear and submit together ----
`ifdef SKETCH_TOGGLE_EN
        press(16'h0001);
`endif
        press(16'h8000);
        chk("t5_live", {16'd0, live_frame}, 32'h8001);
        chk("t5_count", {27'd0, pixel_count}, 32'd2);
        frame_ready = 1'b1;
        tick(3);
        frame_ready = 1'b0;
        chk("t5_stray_ready_live", {16'd0, live_frame}, 32'h8001);
        chk("t5_stray_ready_valid", {31'd0, frame_valid}, 32'd0);
        btn_clear  = 1'b1;
        btn_submit = 1'b1;
        tick(6);
        check_idle_zero("t5_clear_wins");
        chk("t5_frame_kept", {16'd0, frame}, 32'h6996);
        $display("t5 clear+submit: live=%h frame_valid=%0d", live_frame, frame_valid);
        btn_clear  = 1'b0;
        btn_submit = 1'b0;
        tick(6);

        // ---- 6: activity during an offer is dropped ----
        press(16'h0020);
        btn_submit = 1'b1;
        tick(6);
        btn_submit = 1'b0;
        chk("t6_offer_frame", {16'd0, frame}, 32'h0020);
        chk("t6_offer_valid", {31'd0, frame_valid}, 32'd1);
        press(16'h0100);
        btn_clear = 1'b1;
        tick(6);
        btn_clear = 1'b0;
        tick(6);
        chk("t6_held_frame", {16'd0, frame}, 32'h0020);
        chk("t6_held_live", {16'd0, live_frame}, 32'h0020);
        chk("t6_held_valid", {31'd0, frame_valid}, 32'd1);
        frame_ready = 1'b1;
        tick(1);
        frame_ready = 1'b0;
        check_idle_zero("t6_handshake");
        tick(10);
        check_idle_zero("t6_nothing_queued");
        chk("t6_frame_kept", {16'd0, frame}, 32'h0020);
        $display("t6 offer with dropped activity: frame=%h live=%h", frame, live_frame);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
